// File: rtl/io_port_ctrl.sv
// io_port_ctrl: input/output FIFOs between a stalling core and an external stream, plus an instruction-ROM flash loader.
// Optional feature: define IO_LOOPBACK_EN to add the loopback port that routes the OUT head into the IN FIFO.
module io_port_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int ADR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_rd_req,
  output logic [WIDTH-1:0] core_rd_data,
  input  logic             core_wr_req,
  input  logic [WIDTH-1:0] core_wr_data,
  output logic             core_stall,
  output logic             io_waiting,
  input  logic             ext_in_valid,
  output logic             ext_in_ready,
  input  logic [WIDTH-1:0] ext_in_data,
  output logic             ext_out_valid,
  input  logic             ext_out_ready,
  output logic [WIDTH-1:0] ext_out_data,
  input  logic             flash_en,
  output logic             flash_we,
  output logic [ADR_W-1:0] flash_adr,
  output logic [WIDTH-1:0] flash_data,
`ifdef IO_LOOPBACK_EN
  input  logic             loopback,
`endif
  output logic             flash_done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [ADR_W-1:0] ADR_LAST = '1;

  typedef enum logic [1:0] {RUN, FLASH, DONE} state_t;

  state_t           state;
  logic [ADR_W-1:0] load_addr;
  logic             flash_hold;

  logic [WIDTH-1:0] in_mem  [DEPTH];
  logic [WIDTH-1:0] out_mem [DEPTH];
  logic [PW-1:0]    in_wptr, in_rptr, out_wptr, out_rptr;
  logic [CW-1:0]    in_count, out_count;

  logic             in_empty, in_full, out_empty, out_full;
  logic             in_push, in_pop, out_push, out_pop;
  logic             in_flush, out_flush;
  logic             rd_block, wr_block, load_we, start_load;
  logic [WIDTH-1:0] in_din;

  assign in_empty  = (in_count == '0);
  assign in_full   = (in_count == FULL);
  assign out_empty = (out_count == '0);
  assign out_full  = (out_count == FULL);

  // A blocked read or write stalls the whole instruction, so the other half is suppressed too.
  always_comb begin
    start_load = 1'b0;
    rd_block   = 1'b0;
    wr_block   = 1'b0;
    in_push    = 1'b0;
    in_pop     = 1'b0;
    out_push   = 1'b0;
    out_pop    = 1'b0;
    load_we    = 1'b0;
    in_din     = ext_in_data;
    if (reset) begin
      case (state)
        RUN: begin
          start_load = flash_en && !flash_hold;
          rd_block   = core_rd_req && in_empty;
          wr_block   = core_wr_req && out_full;
          in_pop     = core_rd_req && !in_empty && !wr_block;
          out_push   = core_wr_req && !out_full && !rd_block;
`ifdef IO_LOOPBACK_EN
          if (loopback) begin
            in_push = !out_empty && !in_full;
            in_din  = out_mem[out_rptr];
            out_pop = in_push;
          end else begin
            in_push = ext_in_valid && !in_full;
            out_pop = !out_empty && ext_out_ready;
          end
`else
          in_push = ext_in_valid && !in_full;
          out_pop = !out_empty && ext_out_ready;
`endif
        end
        FLASH:   load_we = ext_in_valid;
        default: ;
      endcase
    end
  end

  assign in_flush  = start_load || (state == DONE);
  assign out_flush = start_load;

  always_ff @(posedge clk) begin
    if (!reset || in_flush) begin
      in_wptr  <= '0;
      in_rptr  <= '0;
      in_count <= '0;
    end else begin
      if (in_push) in_wptr <= in_wptr + PW'(1);
      if (in_pop)  in_rptr <= in_rptr + PW'(1);
      if (in_push && !in_pop)      in_count <= in_count + CW'(1);
      else if (!in_push && in_pop) in_count <= in_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || out_flush) begin
      out_wptr  <= '0;
      out_rptr  <= '0;
      out_count <= '0;
    end else begin
      if (out_push) out_wptr <= out_wptr + PW'(1);
      if (out_pop)  out_rptr <= out_rptr + PW'(1);
      if (out_push && !out_pop)      out_count <= out_count + CW'(1);
      else if (!out_push && out_pop) out_count <= out_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wptr]   <= in_din;
    if (out_push) out_mem[out_wptr] <= core_wr_data;
  end

  // flash_hold keeps a held-high flash_en from restarting a load until it is seen low in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      load_addr  <= '0;
      flash_hold <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!flash_en) flash_hold <= 1'b0;
          if (start_load) begin
            state      <= FLASH;
            load_addr  <= '0;
            flash_hold <= 1'b1;
          end
        end
        FLASH: begin
          if (load_we) load_addr <= load_addr + ADR_W'(1);
          if (!flash_en || (load_we && load_addr == ADR_LAST)) state <= DONE;
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign core_rd_data = (reset && !in_empty) ? in_mem[in_rptr] : '0;
  assign ext_out_data = (reset && !out_empty) ? out_mem[out_rptr] : '0;
  assign core_stall   = reset && ((state != RUN) || rd_block || wr_block);
  assign io_waiting   = rd_block;
  assign flash_we     = load_we;
  assign flash_adr    = load_addr;
  assign flash_data   = load_we ? ext_in_data : '0;
  assign flash_done   = reset && (state == DONE);

  // IN is being flushed during DONE, so nothing is accepted there.
`ifdef IO_LOOPBACK_EN
  assign ext_in_ready  = (state == FLASH) || ((state == RUN) && !in_full && !loopback);
  assign ext_out_valid = reset && (state == RUN) && !out_empty && !loopback;
`else
  assign ext_in_ready  = (state == FLASH) || ((state == RUN) && !in_full);
  assign ext_out_valid = reset && (state == RUN) && !out_empty;
`endif

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, data word width of the core, external and flash paths.
REQ-002 Parameter DEPTH, default 4, entries per FIFO; power of two, minimum 2.
REQ-003 Parameter ADR_W, default 8, instruction-ROM address width.
REQ-004 Port clk  in  1  rising-edge clock, the only clock.
REQ-005 Port reset  in  1  reset, synchronous, active-low.
REQ-006 Port core_rd_req  in  1  the core executes an input instruction this cycle.
REQ-007 Port core_rd_data  out  WIDTH  head of the input FIFO.
REQ-008 Port core_wr_req  in  1  the core executes an output instruction this cycle.
REQ-009 Port core_wr_data  in  WIDTH  word the core is writing.
REQ-010 Port core_stall  out  1  the core holds its PC and suppresses writes.
REQ-011 Port io_waiting  out  1  the core is blocked on an empty input FIFO.
REQ-012 Port ext_in_valid / ext_in_ready / ext_in_data  in / out / in  1 / 1 / WIDTH  external input valid/ready handshake.
REQ-013 Port ext_out_valid / ext_out_ready / ext_out_data  out / in / out  1 / 1 / WIDTH  external output valid/ready handshake.
REQ-014 Port flash_en  in  1  request a ROM load from the input stream.
REQ-015 Port flash_we / flash_adr / flash_data  out / out / out  1 / ADR_W / WIDTH  instruction-ROM write port.
REQ-016 Port flash_done  out  1  one-cycle pulse at the end of a load.

Function
REQ-017 Two FIFOs, each DEPTH entries with a registered count: IN (ext to core) and OUT (core to ext).
- Push is visible at the head on the next cycle; there is no same-cycle bypass.
REQ-018 ext_in_ready = IN not full; a push occurs when ext_in_valid && ext_in_ready.
REQ-019 ext_out_valid = OUT not empty; ext_out_data = OUT head; a pop occurs when ext_out_valid && ext_out_ready.
REQ-020 FSM states RUN, FLASH, DONE; reset state is RUN.
REQ-021 In RUN, a read pops IN when core_rd_req && IN not empty.
- If IN is empty, core_stall = 1 and io_waiting = 1.
REQ-022 In RUN, a write pushes OUT when core_wr_req && OUT not full.
- If OUT is full, core_stall = 1 and no push occurs.
REQ-023 core_stall = 0 in RUN when no read or write is blocked.
REQ-024 A simultaneous push and pop on either FIFO leaves its count unchanged.
- A full IN accepts no push, even when a pop occurs in the same cycle.
REQ-025 Pointers wrap modulo DEPTH.
REQ-026 Transition RUN -> FLASH occurs when flash_en = 1 at a clock edge.
- IN and OUT are flushed on entry.
- The load address is cleared to 0.
REQ-027 In FLASH, core_stall = 1 and ext_in_ready = 1.
- Each accepted input word drives flash_we = 1 in the same cycle, with flash_data = ext_in_data and flash_adr = load address.
- The load address then increments.
REQ-028 Transition FLASH -> DONE occurs when flash_en = 0, or when the word at address 2^ADR_W-1 is written; no address wrap is permitted.
REQ-029 In DONE, flash_done = 1 and core_stall = 1 for exactly one cycle.
- The next state is RUN.
- IN is flushed.
REQ-030 In DONE, flash_en = 1 does not restart the load.
- A new load requires flash_en to be seen low in RUN first.
REQ-031 flash_we = 0 outside FLASH.

Reset
REQ-032 When reset = 0 at a clock edge, the block returns to a defined state:
- FSM = RUN; both FIFOs empty; load address = 0.
- Outputs core_stall = 0, io_waiting = 0, ext_in_ready = 1, ext_out_valid = 0, flash_we = 0, flash_done = 0.
- Data outputs = 0.
REQ-033 Reset asserted mid-load aborts the load with no flash_done pulse.
REQ-034 While reset = 0, no handshake completes.

Configuration
REQ-035 Macro IO_LOOPBACK_EN, when defined, adds port loopback (in, 1).
- When loopback = 1, the OUT head feeds the IN push path when IN is not full, and ext_in_ready = 0, ext_out_valid = 0.
REQ-036 When IO_LOOPBACK_EN is undefined, the loopback port and its logic are absent and behaviour is as specified above.

Verification
REQ-037 Push 0x1234, 0xBEEF on ext_in, then core_rd_req for two cycles -> core_rd_data is 0x1234 then 0xBEEF; core_stall = 0.
REQ-038 core_rd_req with IN empty for 3 cycles, then ext push 0x0042 -> io_waiting = 1 for 4 cycles; the read completes on cycle 5 with 0x0042.
REQ-039 DEPTH=4, ext_out_ready = 0, five core writes -> the fifth stalls; raising ext_out_ready drains 4 words in order and releases the stall.
REQ-040 flash_en = 1, stream 3 words 0xA001..0xA003, then flash_en = 0 -> flash_we at adr 0,1,2; then flash_done pulses once; then RUN.
REQ-041 ADR_W=2 flash with 6 words offered -> exactly 4 writes at adr 0..3; then DONE; no write wraps to adr 0.
REQ-042 reset = 0 during the second flash word -> the next cycle is RUN with both FIFOs empty, flash_we = 0 and no flash_done.
